// File: rtl/risc16_pkg.sv
// risc16_pkg: shared ISA constants plus the memory-arbiter FSM state and
// owner-tag encodings.
package risc16_pkg;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_ADDI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_JR, OP_LUI, OP_HALT
   } opcode_t;
   typedef enum logic [1:0] {IT_R, IT_I, IT_M, IT_J} itype_t;
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} arb_state_t;
   typedef struct packed {
      logic valid;
      logic is_data;
   } tag_t;
   localparam tag_t TAG_NONE  = '{valid: 1'b0, is_data: 1'b0};
   localparam tag_t TAG_FETCH = '{valid: 1'b1, is_data: 1'b0};
   localparam tag_t TAG_DATA  = '{valid: 1'b1, is_data: 1'b1};
   function automatic itype_t op_itype(input opcode_t op);
      return (op inside {OP_LW, OP_SW}) ? IT_M :
             (op inside {OP_JAL, OP_JR}) ? IT_J :
             (op >= OP_ADDI) ? IT_I : IT_R;
   endfunction
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-over-fetch priority with a saturating starvation
// counter that forces a waiting fetch through once it reaches STARVE_MAX.
module mem_arb_prio #(
   parameter int STARVE_MAX = 4
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic       if_req,
   input  logic       d_req,
   input  logic       run,
   output logic       if_gnt,
   output logic       d_gnt,
   output logic [2:0] starve_cnt
);
   logic [2:0] starve_q, starve_d;
   logic       force_fetch;
   always_comb begin
      force_fetch = starve_q == 3'(STARVE_MAX);
      if_gnt      = !rst && run && if_req && (!d_req || force_fetch);
      d_gnt       = !rst && d_req && !if_gnt;
      // counter is frozen whenever fetch is blocked by a drain/halt
      starve_d    = !run ? starve_q :
                    if_gnt ? 3'd0 :
                    (if_req && starve_q < 3'(STARVE_MAX)) ? starve_q + 3'd1 : starve_q;
      starve_cnt  = starve_q;
   end
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) starve_q <= 3'd0;
      else     starve_q <= starve_d;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between instruction fetch
// and the LW/SW data port, with a halt/drain FSM and read-response routing.
module mem_arbiter
   import risc16_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              halt_req,
   output logic              halt_ack,
   output logic [2:0]        starve_cnt
);
   arb_state_t        state_q, state_d;
   tag_t              tag_q, tag_d;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
   logic              run;
   assign run = state_q == ST_RUN;
   mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
      .clk1       (clk1),
      .rst        (rst),
      .if_req     (if_req),
      .d_req      (d_req),
      .run        (run),
      .if_gnt     (if_gnt),
      .d_gnt      (d_gnt),
      .starve_cnt (starve_cnt)
   );
   always_comb begin
      if_rvalid = tag_q.valid && !tag_q.is_data;
      d_rvalid  = tag_q.valid && tag_q.is_data;
      state_d   = state_q;
      case (state_q)
         ST_RUN:   state_d = halt_req ? ST_DRAIN : ST_RUN;
         // the fetch read being returned this cycle still counts as outstanding
         ST_DRAIN: state_d = !halt_req ? ST_RUN : if_rvalid ? ST_DRAIN : ST_HALTED;
         default:  state_d = halt_req ? ST_HALTED : ST_RUN;
      endcase
      tag_d     = if_gnt ? TAG_FETCH : (d_gnt && !d_we) ? TAG_DATA : TAG_NONE;
      mem_en    = if_gnt || d_gnt;
      mem_we    = d_gnt && d_we;
      mem_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
      mem_wdata = d_gnt ? d_wdata : '0;
      if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
      d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
      halt_ack  = state_q == ST_HALTED;
   end
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         tag_q      <= TAG_NONE;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         if (if_rvalid) if_rdata_q <= mem_rdata;
         if (d_rvalid)  d_rdata_q  <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int SM = 4;
   logic          clk1 = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt_req = 1'b0;
   logic [AW-1:0] if_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, halt_ack;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [2:0]    starve_cnt;
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] wmem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   always #5 clk1 = ~clk1;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk1(clk1), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .halt_req(halt_req), .halt_ack(halt_ack), .starve_cnt(starve_cnt)
   );

   function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
      return 32'hC0DE0000 | 32'(a);
   endfunction

   always @(posedge clk1) begin
      if (mem_en) begin
         if (mem_we) wmem[mem_addr] = mem_wdata;
         else mem_rdata <= wmem.exists(mem_addr) ? wmem[mem_addr] : mem_init(mem_addr);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   // Model: mode 0=running, 1=draining, 2=halted; pend -1=none, 0=fetch read, 1=data read
   int            m_mode, m_starve, m_pend;
   logic [DW-1:0] m_pval, m_if_last, m_d_last;
   logic          e_if, e_d;
   logic [AW-1:0] e_addr;
   initial begin
      m_mode = 0; m_starve = 0; m_pend = -1;
      m_pval = '0; m_if_last = '0; m_d_last = '0;
      forever begin
         @(negedge clk1);
         if (rst) begin
            m_mode = 0; m_starve = 0; m_pend = -1;
            m_if_last = '0; m_d_last = '0;
         end
         e_if   = !rst && m_mode == 0 && if_req && (!d_req || m_starve == SM);
         e_d    = !rst && d_req && !e_if;
         e_addr = e_d ? d_addr : e_if ? if_addr : '0;
         check("m_if_gnt", if_gnt, e_if);
         check("m_d_gnt", d_gnt, e_d);
         check("m_mem_en", mem_en, e_if || e_d);
         check("m_mem_we", mem_we, e_d && d_we);
         check("m_mem_addr", mem_addr, e_addr);
         check("m_mem_wdata", mem_wdata, e_d ? d_wdata : '0);
         check("m_starve", starve_cnt, 64'(m_starve));
         check("m_halt_ack", halt_ack, m_mode == 2);
         check("m_if_rvalid", if_rvalid, m_pend == 0);
         check("m_d_rvalid", d_rvalid, m_pend == 1);
         check("m_if_rdata", if_rdata, m_pend == 0 ? m_pval : m_if_last);
         check("m_d_rdata", d_rdata, m_pend == 1 ? m_pval : m_d_last);
         if (!rst) begin
            if (m_pend == 0) m_if_last = m_pval;
            if (m_pend == 1) m_d_last = m_pval;
            if (m_mode == 0) m_starve = e_if ? 0 : (if_req && m_starve < SM) ? m_starve + 1 : m_starve;
            if (m_mode == 0) m_mode = halt_req ? 1 : 0;
            else if (m_mode == 1) m_mode = !halt_req ? 0 : (m_pend == 0) ? 1 : 2;
            else m_mode = halt_req ? 2 : 0;
            m_pend = -1;
            if (e_if) begin
               m_pend = 0;
               m_pval = ref_mem.exists(if_addr) ? ref_mem[if_addr] : mem_init(if_addr);
            end else if (e_d && d_we) ref_mem[d_addr] = d_wdata;
            else if (e_d) begin
               m_pend = 1;
               m_pval = ref_mem.exists(d_addr) ? ref_mem[d_addr] : mem_init(d_addr);
            end
         end
      end
   end

   logic g_if, g_d;
   initial begin
      // requests during reset must be ignored
      if_req = 1; d_req = 1; if_addr = 4; d_addr = 3;
      step(); step(); #3;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_starve", starve_cnt, 0);
      check("rst_halt_ack", halt_ack, 0);
      step(); rst = 0; if_req = 0; d_req = 0;
      step(); if_req = 1; if_addr = 5; #3;
      check("fetch5_gnt", if_gnt, 1);
      check("fetch5_addr", mem_addr, 5);
      step(); if_req = 0; #3;
      check("fetch5_rvalid", if_rvalid, 1);
      check("fetch5_rdata", if_rdata, 32'hC0DE0005);
      step(); d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'hA5A5; if_req = 1; if_addr = 0; #3;
      check("wr7_d_gnt", d_gnt, 1);
      check("wr7_mem_we", mem_we, 1);
      check("wr7_if_gnt", if_gnt, 0);
      check("wr7_wdata", mem_wdata, 32'hA5A5);
      step(); d_req = 0; d_we = 0; #3;
      check("wr7_starve", starve_cnt, 1);
      check("wr7_if_gnt_after", if_gnt, 1);
      step(); if_req = 0; #3;
      check("wr7_starve_clr", starve_cnt, 0);
      step(); d_req = 1; d_addr = 7; #3;
      check("rd7_gnt", d_gnt, 1);
      step(); d_req = 0; #3;
      check("rd7_rvalid", d_rvalid, 1);
      check("rd7_rdata", d_rdata, 32'hA5A5);
      step(); d_req = 1; d_addr = 10; if_req = 1; if_addr = 20;
      for (int k = 0; k < 5; k++) begin
         #3;
         check("starve_if_gnt", if_gnt, k == 4);
         check("starve_d_gnt", d_gnt, k != 4);
         check("starve_cnt", starve_cnt, 64'(k));
         step();
      end
      if_req = 0; #3;
      check("starve_after", starve_cnt, 0);
      check("starve_d_resume", d_gnt, 1);
      step(); d_req = 0;
      step(); if_req = 1; if_addr = 3; #3;
      check("halt_fetch_gnt", if_gnt, 1);
      step(); if_req = 0; halt_req = 1; #3;
      check("halt_if_rvalid", if_rvalid, 1);
      check("halt_ack_t0", halt_ack, 0);
      step(); if_req = 1; d_req = 1; d_addr = 9; #3;
      check("drain_if_gnt", if_gnt, 0);
      check("drain_d_gnt", d_gnt, 1);
      check("halt_ack_t1", halt_ack, 0);
      step(); d_req = 0; #3;
      check("halt_ack_t2", halt_ack, 1);
      check("halted_if_gnt", if_gnt, 0);
      check("drain_d_rvalid", d_rvalid, 1);
      check("drain_d_rdata", d_rdata, 32'hC0DE0009);
      check("halted_starve", starve_cnt, 0);
      step(); d_req = 1; d_addr = 7; #3;
      check("halted_d_gnt", d_gnt, 1);
      step(); d_req = 0; halt_req = 0; #3;
      check("halted_hold_ack", halt_ack, 1);
      step(); #3;
      check("resume_ack", halt_ack, 0);
      check("resume_if_gnt", if_gnt, 1);
      step(); if_req = 0;
      step(); d_req = 1; d_addr = 11; #3;
      check("rstrd_gnt", d_gnt, 1);
      step(); d_req = 0; rst = 1; #3;
      check("rstrd_d_rvalid", d_rvalid, 0);
      check("rstrd_d_rdata", d_rdata, 0);
      check("rstrd_if_rdata", if_rdata, 0);
      check("rstrd_mem_en", mem_en, 0);
      step(); rst = 0;
      step(); #3;
      check("rstrd_rvalid_after", d_rvalid, 0);
      check("rstrd_rdata_after", d_rdata, 0);
      step();
      for (int i = 0; i < 8; i++) begin
         if_req = !i[0]; d_req = i[0]; d_we = 0;
         if_addr = AW'(40 + i); d_addr = AW'(40 + i);
         #3;
         check("b2b_gnt", i[0] ? d_gnt : if_gnt, 1);
         if (i > 0) begin
            check("b2b_rvalid_own", i[0] ? if_rvalid : d_rvalid, 1);
            check("b2b_rvalid_other", i[0] ? d_rvalid : if_rvalid, 0);
            check("b2b_rdata", i[0] ? if_rdata : d_rdata, 32'hC0DE0000 + 32'(40 + i - 1));
         end
         step();
      end
      if_req = 0; d_req = 0; #3;
      check("b2b_last_rvalid", d_rvalid, 1);
      check("b2b_last_rdata", d_rdata, 32'hC0DE002F);
      step();
      g_if = 0; g_d = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = rst ? 1'b0 : ($urandom_range(0, 299) == 0);
         if (!if_req || g_if) begin
            if_req = $urandom_range(0, 1) == 1;
            if_addr = AW'($urandom);
         end
         if (!d_req || g_d) begin
            d_req = $urandom_range(0, 2) != 0;
            d_we = $urandom_range(0, 2) == 0;
            d_addr = AW'($urandom_range(0, 31));
            d_wdata = $urandom;
         end
         if ($urandom_range(0, 24) == 0) halt_req = !halt_req;
         #3;
         g_if = if_gnt; g_d = d_gnt;
         step();
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
